// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the two requester ports and the shared decoder-side bus of the
//   memory-mapped data bus arbiter.
//
//   Requester ports (mN_*, N = 0 CPU load/store, N = 1 loader/DMA):
//     mN_req, mN_we, mN_addr[31:0], mN_wdata[31:0], mN_wmask[3:0]  to arbiter
//     mN_ack, mN_err, mN_rdata[31:0]                               from arbiter
//   Decoder side:
//     bus_addr[31:0], bus_we, bus_wdata[31:0], bus_wmask[3:0]      from arbiter
//     bus_rdata[31:0]                                              to arbiter
//   Status:
//     busy                                                         from arbiter
//
//   Modport slave is the arbiter's view; modport master is the view of the
//   surrounding system (requesters plus decoder).
interface mem_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wmask;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wmask;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;

    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic [31:0] bus_rdata;

    logic        busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
        output m1_ack, m1_err, m1_rdata,
        output bus_addr, bus_we, bus_wdata, bus_wmask,
        input  bus_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
        input  m1_ack, m1_err, m1_rdata,
        input  bus_addr, bus_we, bus_wdata, bus_wmask,
        output bus_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master round-robin arbiter for the memory-mapped data bus. Each
//   granted access runs as one fixed-length bus transaction with a per-region
//   wait count, and completes with a one-cycle ack (plus registered read
//   data) to the owning master. Accesses to unmapped regions never reach the
//   bus; they complete through the ERR state with ack and err together.
//
//   Ports:
//     clk    system clock, rising edge
//     rst    synchronous active-high reset
//     ports  mem_bus_arbiter_if.slave (requester ports, decoder bus, busy)
module mem_bus_arbiter #(
    parameter int unsigned WAIT_DMEM    = 1,
    parameter int unsigned WAIT_CMEM    = 1,
    parameter int unsigned WAIT_DEFAULT = 0
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.slave    ports
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2
    } state_t;

    state_t      state;
    logic        owner;       // 0: master 0 owns the transaction, 1: master 1
    logic        last_grant;  // master granted most recently; reset to 1 so master 0 wins first
    logic        lat_we;
    logic [7:0]  wait_cnt;

    logic        sel_m1;
    logic        req_any;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;

    function automatic logic region_mapped(input logic [3:0] id);
        case (id)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'h7, 4'h8, 4'hF: region_mapped = 1'b1;
            default:                region_mapped = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] region_wait(input logic [3:0] id);
        case (id)
            4'h1:    region_wait = 8'(WAIT_DMEM);
            4'h4:    region_wait = 8'(WAIT_CMEM);
            default: region_wait = 8'(WAIT_DEFAULT);
        endcase
    endfunction

    // Master 1 wins when it is the only requester, or when both request and
    // master 0 was the one granted last.
    always_comb begin
        req_any   = ports.m0_req | ports.m1_req;
        sel_m1    = ports.m1_req & (~ports.m0_req | ~last_grant);
        req_we    = sel_m1 ? ports.m1_we    : ports.m0_we;
        req_addr  = sel_m1 ? ports.m1_addr  : ports.m0_addr;
        req_wdata = sel_m1 ? ports.m1_wdata : ports.m0_wdata;
        req_wmask = sel_m1 ? ports.m1_wmask : ports.m0_wmask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            owner           <= 1'b0;
            last_grant      <= 1'b1;
            lat_we          <= 1'b0;
            wait_cnt        <= 8'd0;
            ports.m0_ack    <= 1'b0;
            ports.m0_err    <= 1'b0;
            ports.m0_rdata  <= 32'd0;
            ports.m1_ack    <= 1'b0;
            ports.m1_err    <= 1'b0;
            ports.m1_rdata  <= 32'd0;
            ports.bus_addr  <= 32'd0;
            ports.bus_we    <= 1'b0;
            ports.bus_wdata <= 32'd0;
            ports.bus_wmask <= 4'd0;
        end else begin
            // Acks and the write strobe are single-cycle pulses.
            ports.m0_ack <= 1'b0;
            ports.m1_ack <= 1'b0;
            ports.bus_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner  <= sel_m1;
                        lat_we <= req_we;
                        if (region_mapped(req_addr[23:20])) begin
                            ports.bus_addr  <= req_addr;
                            ports.bus_wdata <= req_wdata;
                            ports.bus_wmask <= req_wmask;
                            // Strobe only in the first ACCESS cycle so the
                            // write lands exactly once regardless of waits.
                            ports.bus_we    <= req_we;
                            wait_cnt        <= region_wait(req_addr[23:20]);
                            state           <= ACCESS;
                        end else begin
                            state <= ERR;
                        end
                    end
                end

                ACCESS: begin
                    if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else begin
                        if (owner) begin
                            ports.m1_ack   <= 1'b1;
                            ports.m1_err   <= 1'b0;
                            ports.m1_rdata <= lat_we ? 32'd0 : ports.bus_rdata;
                        end else begin
                            ports.m0_ack   <= 1'b1;
                            ports.m0_err   <= 1'b0;
                            ports.m0_rdata <= lat_we ? 32'd0 : ports.bus_rdata;
                        end
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end

                ERR: begin
                    if (owner) begin
                        ports.m1_ack   <= 1'b1;
                        ports.m1_err   <= 1'b1;
                        ports.m1_rdata <= 32'd0;
                    end else begin
                        ports.m0_ack   <= 1'b1;
                        ports.m0_err   <= 1'b1;
                        ports.m0_rdata <= 32'd0;
                    end
                    last_grant <= owner;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign ports.busy = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed-vector bench for mem_bus_arbiter: single reads/writes with wait
//   states, round-robin alternation, unmapped accesses, reset in the middle of
//   a transaction, and a requester dropping req mid-transaction.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_rd = 32'd0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if ifc();
    assign ifc.bus_rdata = bus_rd;

    mem_bus_arbiter #(
        .WAIT_DMEM    (1),
        .WAIT_CMEM    (1),
        .WAIT_DEFAULT (0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ports (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Bus / ack monitor, sampled mid-cycle.
    int          we_cycles = 0;
    int          acks0     = 0;
    int          acks1     = 0;
    int          overlap   = 0;
    logic [31:0] we_addr   = 32'd0;
    logic [31:0] we_wdata  = 32'd0;
    logic [3:0]  we_wmask  = 4'd0;

    always @(negedge clk) begin
        if (ifc.bus_we) begin
            we_cycles <= we_cycles + 1;
            we_addr   <= ifc.bus_addr;
            we_wdata  <= ifc.bus_wdata;
            we_wmask  <= ifc.bus_wmask;
        end
        if (ifc.m0_ack) acks0 <= acks0 + 1;
        if (ifc.m1_ack) acks1 <= acks1 + 1;
        if (ifc.m0_ack && ifc.m1_ack) overlap <= overlap + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit m, input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
        if (m) begin
            ifc.m1_req = req; ifc.m1_we = we; ifc.m1_addr = addr;
            ifc.m1_wdata = wdata; ifc.m1_wmask = wmask;
        end else begin
            ifc.m0_req = req; ifc.m0_we = we; ifc.m0_addr = addr;
            ifc.m0_wdata = wdata; ifc.m0_wmask = wmask;
        end
    endtask

    // Issue one request and hold it until its ack; lat counts cycles from the
    // sampling edge to the cycle in which the ack is visible.
    task automatic run_txn(input bit m, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           output int lat, output logic [31:0] rd, output logic err);
        logic ack;
        lat = 0; rd = 32'd0; err = 1'b0; ack = 1'b0;
        drive(m, 1'b1, we, addr, wdata, wmask);
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            ack = m ? ifc.m1_ack : ifc.m0_ack;
            if (ack) begin
                rd  = m ? ifc.m1_rdata : ifc.m0_rdata;
                err = m ? ifc.m1_err   : ifc.m0_err;
                break;
            end
        end
        if (m) ifc.m1_req = 1'b0; else ifc.m0_req = 1'b0;
        if (!ack) check_eq("txn_ack_seen", {31'd0, ack}, 32'd1);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        err;
    int          w0, a0, a1, ov0;
    int          rem0, rem1;
    int          order[$];
    int          exp_order[6] = '{0, 1, 0, 1, 0, 1};
    int          got_ord;
    logic        seen;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        rst = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_busy",     {31'd0, ifc.busy},   32'd0);
        check_eq("rst_m0_ack",   {31'd0, ifc.m0_ack}, 32'd0);
        check_eq("rst_m1_ack",   {31'd0, ifc.m1_ack}, 32'd0);
        check_eq("rst_bus_we",   {31'd0, ifc.bus_we}, 32'd0);
        check_eq("rst_m0_rdata", ifc.m0_rdata,        32'd0);
        check_eq("rst_bus_addr", ifc.bus_addr,        32'd0);
        rst = 1'b0;
        tick();

        // m0 reads dmem (one wait state)
        bus_rd = 32'hDEAD_BEEF;
        w0 = we_cycles;
        run_txn(1'b0, 1'b0, 32'h0010_0040, 32'd0, 4'd0, lat, rd, err);
        check_eq("dmem_rd_lat",   32'(lat), 32'd3);
        check_eq("dmem_rd_data",  rd,       32'hDEAD_BEEF);
        check_eq("dmem_rd_err",   {31'd0, err}, 32'd0);
        tick();
        check_eq("dmem_rd_ack_pulse", {31'd0, ifc.m0_ack}, 32'd0);
        check_eq("dmem_rd_no_we", 32'(we_cycles - w0), 32'd0);

        // m1 writes led (no wait state)
        bus_rd = 32'hFFFF_FFFF;
        w0 = we_cycles;
        run_txn(1'b1, 1'b1, 32'h0070_0000, 32'h0000_00A5, 4'b0001, lat, rd, err);
        check_eq("led_wr_lat",    32'(lat), 32'd2);
        check_eq("led_wr_rdata",  rd,       32'd0);
        check_eq("led_wr_we_cyc", 32'(we_cycles - w0), 32'd1);
        check_eq("led_wr_addr",   we_addr,  32'h0070_0000);
        check_eq("led_wr_wdata",  we_wdata, 32'h0000_00A5);
        check_eq("led_wr_wmask",  {28'd0, we_wmask}, 32'd1);

        // Round-robin from reset: both hold for three transactions each
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus_rd = 32'h1234_5678;
        ov0 = overlap;
        rem0 = 3; rem1 = 3;
        drive(1'b0, 1'b1, 1'b0, 32'h0030_0000, 32'd0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0030_0000, 32'd0, 4'd0);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ifc.m0_ack) begin
                order.push_back(0);
                rem0--;
                if (rem0 == 0) ifc.m0_req = 1'b0;
            end
            if (ifc.m1_ack) begin
                order.push_back(1);
                rem1--;
                if (rem1 == 0) ifc.m1_req = 1'b0;
            end
            if (rem0 <= 0 && rem1 <= 0) break;
        end
        ifc.m0_req = 1'b0;
        ifc.m1_req = 1'b0;
        check_eq("rr_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            got_ord = (i < order.size()) ? order[i] : -1;
            check_eq($sformatf("rr_order_%0d", i), 32'(got_ord), 32'(exp_order[i]));
        end
        check_eq("rr_no_overlap", 32'(overlap - ov0), 32'd0);
        check_eq("rr_m0_rdata",   ifc.m0_rdata, 32'h1234_5678);
        tick();

        // m0 reads an unmapped region
        w0 = we_cycles;
        run_txn(1'b0, 1'b0, 32'h00A0_0000, 32'd0, 4'd0, lat, rd, err);
        check_eq("unmap_lat",   32'(lat), 32'd2);
        check_eq("unmap_err",   {31'd0, err}, 32'd1);
        check_eq("unmap_rdata", rd, 32'd0);
        check_eq("unmap_no_we", 32'(we_cycles - w0), 32'd0);
        tick();

        // Reset during the second cycle of a cmem write by m0
        w0 = we_cycles;
        a0 = acks0;
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0010, 32'h0000_0055, 4'hF);
        tick();
        check_eq("cmem_busy", {31'd0, ifc.busy}, 32'd1);
        tick();
        rst = 1'b1;
        ifc.m0_req = 1'b0;
        tick();
        check_eq("cmem_rst_busy", {31'd0, ifc.busy},   32'd0);
        check_eq("cmem_rst_ack",  {31'd0, ifc.m0_ack}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check_eq("cmem_rst_no_ack", 32'(acks0 - a0), 32'd0);
        check_eq("cmem_we_once",    32'(we_cycles - w0), 32'd1);

        drive(1'b0, 1'b1, 1'b0, 32'h0030_0000, 32'd0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0030_0000, 32'd0, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifc.m0_ack || ifc.m1_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("post_rst_m0_first", {31'd0, ifc.m0_ack}, {31'd0, seen});
        check_eq("post_rst_m1_not",   {31'd0, ifc.m1_ack}, 32'd0);
        ifc.m0_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifc.m1_ack) begin
                seen = 1'b1;
                break;
            end
        end
        ifc.m1_req = 1'b0;
        check_eq("post_rst_m1_done", {31'd0, seen}, 32'd1);
        tick();

        // m1 drops req one cycle into a dmem read
        bus_rd = 32'hCAFE_0001;
        a1 = acks1;
        drive(1'b1, 1'b1, 1'b0, 32'h0010_0000, 32'd0, 4'd0);
        tick();
        ifc.m1_req = 1'b0;
        tick();
        check_eq("drop_ack_early", {31'd0, ifc.m1_ack}, 32'd0);
        tick();
        check_eq("drop_ack_t3",    {31'd0, ifc.m1_ack}, 32'd1);
        check_eq("drop_rdata",     ifc.m1_rdata, 32'hCAFE_0001);
        check_eq("drop_err",       {31'd0, ifc.m1_err}, 32'd0);
        repeat (4) tick();
        check_eq("drop_ack_once",  32'(acks1 - a1), 32'd1);
        check_eq("drop_idle_busy", {31'd0, ifc.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory-mapped data bus (the address-decoded path to dmem, seg, timer, cmem, kbd, sw, led, vga, serial) between two requesters.
  - Master 0: CPU load/store unit.
  - Master 1: program loader / DMA engine.
- Sequences each access as a fixed-length bus transaction with per-region wait states.
- Returns read data plus a one-cycle ack to the owning master.
- Flags accesses to unmapped regions without issuing a bus cycle.

Parameters:
- WAIT_DMEM, 1, extra wait cycles for region id 4'h1 (synchronous-read dmem).
- WAIT_CMEM, 1, extra wait cycles for region id 4'h4 (char memory).
- WAIT_DEFAULT, 0, extra wait cycles for every other mapped region.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_wmask  in  4  master 0 byte mask.
- m0_ack  out  1  master 0 transaction complete (1-cycle pulse).
- m0_err  out  1  master 0 unmapped access; valid with m0_ack.
- m0_rdata  out  32  master 0 read data; valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_wmask, m1_ack, m1_err, m1_rdata: same as m0_* for master 1.
- bus_addr  out  32  address to decoder.
- bus_we  out  1  write strobe to decoder.
- bus_wdata  out  32  write data.
- bus_wmask  out  4  byte mask.
- bus_rdata  in  32  muxed read data from decoder.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Region id = addr[23:20].
  - Mapped ids: 1,2,3,4,5,6,7,8,F.
  - All other ids are unmapped.
- States: IDLE, ACCESS, ERR.
- Reset:
  - State goes to IDLE.
  - All acks, errs and bus_we go to 0.
  - rdata outputs, bus_addr, bus_wdata and bus_wmask go to 0.
  - Round-robin pointer set so that master 0 has priority.
  - Applies mid-transaction: the in-flight access is abandoned and no ack is issued.
- IDLE:
  - No request pending: stay in IDLE.
  - Request pending, arbitration:
    - Only one master requesting: that master wins.
    - Both requesting: the master not granted last wins (round-robin).
  - On win, latch the winner's id, we, addr, wdata and wmask.
  - Mapped region: load wait counter with the region's wait count; go to ACCESS.
  - Unmapped region: go to ERR.
- ACCESS:
  - bus_addr, bus_wdata and bus_wmask are driven from the latched values for the whole state.
  - bus_we is high only in the first ACCESS cycle, and only for writes, so a write occurs exactly once.
  - Counter nonzero: decrement it.
  - Counter zero:
    - Register bus_rdata into the winner's rdata (0 for writes).
    - Pulse the winner's ack on the next cycle.
    - Update the round-robin pointer.
    - Return to IDLE.
- ERR:
  - Next cycle, pulse the winner's ack and err; rdata = 0.
  - No bus_we at any point.
  - Round-robin pointer updated; return to IDLE.
- Latency from request sampled in IDLE (cycle t) to ack:
  - Mapped region: cycle t+2+W (t+1 enters ACCESS, W wait cycles, ack registered).
  - Unmapped region: cycle t+2.
- Request hold rules:
  - A master that drops req mid-transaction does not cancel it; the transaction completes and the ack is still pulsed.
  - Master inputs are ignored while not granted or while in ACCESS/ERR.
- Output rules:
  - Exactly one ack per granted transaction; m0_ack and m1_ack are never high together.
  - rdata and err hold their last value between acks.
  - Outputs idle (bus_we = 0) in IDLE and ERR.

Test Plan:
- m0 reads addr 0x0010_0040 (dmem, WAIT_DMEM=1), decoder returns 0xDEAD_BEEF → bus_we never high; m0_ack pulses at t+3; m0_rdata = 0xDEAD_BEEF.
- m1 writes 0x0070_0000 (led), wdata 0x0000_00A5, wmask 4'b0001 → bus_we high for exactly 1 cycle with those values; m1_ack at t+2; m1_rdata = 0.
- Both req from reset, each holding for 3 transactions to 0x0030_0000 → grant order m0, m1, m0, m1, m0, m1; no overlapping acks.
- m0 reads 0x00A0_0000 (unmapped) → bus_we stays 0; m0_ack and m0_err high together at t+2; m0_rdata = 0.
- Assert rst in 2nd cycle of a cmem write → no ack, busy = 0 next cycle, next m1 + m0 simultaneous request grants m0.
- m1 drops req one cycle into a dmem read → m1_ack still pulses once at t+3.
